iq_binner: RTL and testbench
============================

Name: iq_binner

Overview:
- Downstream of the integrator: takes each integrated shot (iq_valid, i_val, q_val) and accumulates a 2-D IQ histogram when analyze_mode selects binning.
- Bin geometry comes from config_params (x/y_bin_min, x/y_bin_width, x/y_bin_num).
- Bin index is found by iterative subtraction, so the block has no divider.
- Host reads the histogram through a registered read port; the block keeps shot, out-of-range and dropped-shot statistics.

Parameters:
- COUNT_W, 16, width of each histogram bin counter (saturating).
- STAT_W, 16, width of oor_count and drop_count (saturating).

Ports:
- clk100  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- bin_en  in  1  high when analyze_mode == 2'd1; shots are ignored (not counted as dropped) when low
- iq_valid  in  1  one-cycle pulse from integrator
- i_val  in  32  signed integrated I
- q_val  in  32  signed integrated Q
- x_bin_min, y_bin_min  in  16  signed bin origin
- x_bin_width, y_bin_width  in  16  unsigned bin width
- x_bin_num, y_bin_num  in  5  bins per axis
- clear_hist  in  1  pulse; zero all bins and statistics
- rd_en  in  1  histogram read request
- rd_x, rd_y  in  5  read bin coordinates
- rd_data  out  COUNT_W  bin count
- rd_valid  out  1  rd_data valid
- ready  out  1  high only in IDLE
- bin_done  out  1  one-cycle pulse per processed shot
- bin_x, bin_y  out  5  bin of last shot
- bin_oor  out  1  last shot out of range (qualified by bin_done)
- shot_count  out  32  shots binned in range (wraps)
- oor_count, drop_count  out  STAT_W  saturating

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0 and state goes to CLEAR.
  - On release the block sweeps the 1024-entry RAM (address = {y,x}) one entry per cycle, 1024 cycles, then enters IDLE.
  - A reset asserted mid-operation aborts the operation; the shot in flight is lost and not counted.
- IDLE:
  - On a rising edge with clear_hist=1: go to CLEAR and zero shot_count, oor_count and drop_count. If iq_valid&bin_en on the same edge, the shot is dropped and drop_count is set to 1 after the clear.
  - Else if iq_valid&bin_en: latch offx = sext33(i_val) − sext33(x_bin_min) and offy likewise; idx_x = idx_y = 0; go to LOCATE.
- LOCATE, per axis per edge, until both axes are resolved:
  - if off < 0, width == 0, or idx == num: mark the axis oor;
  - else if off < width: mark the axis resolved;
  - else off −= width, idx += 1.
  - Any axis oor: go to IDLE, pulse bin_done with bin_oor=1, oor_count += 1 (saturating). bin_x/bin_y hold the current idx values.
  - Both axes resolved: go to READ.
  - Resolution edge for an axis is the (idx+1)th LOCATE edge. At most 32 LOCATE edges.
- READ: register mem[{idx_y,idx_x}]; go to WRITE.
- WRITE:
  - mem <= count + 1, saturating at 2^COUNT_W − 1.
  - Pulse bin_done with bin_oor=0, bin_x=idx_x, bin_y=idx_y; shot_count += 1; go to IDLE.
- Latency from the iq_valid edge to bin_done high:
  - in range: max(ix,iy)+3 cycles;
  - out of range: edge on which oor is detected.
- iq_valid&bin_en while not IDLE (including CLEAR): shot dropped, drop_count += 1 (saturating).
- Histogram reads:
  - rd_en sampled on any edge; rd_data/rd_valid registered on the next edge.
  - During CLEAR, rd_data = 0.
  - A read of the address being written in WRITE on the same edge returns the old value.
- bin_num > 31 is impossible (5-bit input). Config changes mid-shot take effect on the next latch; width and num are read live during LOCATE.

Test Plan:
- Reset → 1024 cycles of ready=0, then ready=1; rd(3,4) → rd_data=0, rd_valid=1 one cycle later.
- Config min=0, width=100, num=10; shot i=250, q=730 → bin_done 10 cycles later with bin_x=2, bin_y=7, bin_oor=0; rd(2,7)=1; shot_count=1.
- Shot i=−5, q=50 → bin_done after 1 cycle, bin_oor=1, oor_count=1, no RAM change. Shot i=1000 → bin_oor=1 after 11 cycles.
- COUNT_W=2: four shots into bin (0,0) → rd(0,0)=3 (saturated), shot_count=4.
- Second iq_valid 2 cycles after the first → drop_count=1 and only one bin_done. iq_valid with bin_en=0 → no bin_done and no counter change.
- clear_hist together with iq_valid in IDLE → all bins 0, shot_count=0, drop_count=1. Reset asserted during LOCATE → outputs 0 immediately, clear sweep runs.

Source files
------------

// File: rtl/iq_binner.sv
// iq_binner: accumulates a 2-D IQ histogram of integrated shots in a 1024-entry RAM.
// Bin indices are found by repeated subtraction of the bin width, so no divider is needed.
module iq_binner #(
  parameter int COUNT_W = 16,
  parameter int STAT_W  = 16
) (
  input  logic                clk100,
  input  logic                reset,
  input  logic                bin_en,
  input  logic                iq_valid,
  input  logic signed [31:0]  i_val,
  input  logic signed [31:0]  q_val,
  input  logic signed [15:0]  x_bin_min,
  input  logic signed [15:0]  y_bin_min,
  input  logic [15:0]         x_bin_width,
  input  logic [15:0]         y_bin_width,
  input  logic [4:0]          x_bin_num,
  input  logic [4:0]          y_bin_num,
  input  logic                clear_hist,
  input  logic                rd_en,
  input  logic [4:0]          rd_x,
  input  logic [4:0]          rd_y,
  output logic [COUNT_W-1:0]  rd_data,
  output logic                rd_valid,
  output logic                ready,
  output logic                bin_done,
  output logic [4:0]          bin_x,
  output logic [4:0]          bin_y,
  output logic                bin_oor,
  output logic [31:0]         shot_count,
  output logic [STAT_W-1:0]   oor_count,
  output logic [STAT_W-1:0]   drop_count
);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOCATE, S_READ, S_WRITE} state_t;

  state_t                r_state, w_next;
  logic [9:0]            r_clr_addr;
  logic [COUNT_W-1:0]    r_mem [1024];
  logic [COUNT_W-1:0]    r_cnt;
  logic signed [32:0]    r_offx, r_offy;
  logic [4:0]            r_idx_x, r_idx_y;
  logic                  r_res_x, r_res_y;
  logic [COUNT_W-1:0]    r_rd_data;
  logic                  r_rd_valid, r_bin_done, r_bin_oor;
  logic [4:0]            r_bin_x, r_bin_y;
  logic [31:0]           r_shot_count;
  logic [STAT_W-1:0]     r_oor_count, r_drop_count;

  logic                  w_shot, w_oor_x, w_oor_y, w_hit_x, w_hit_y, w_oor, w_both;
  logic signed [32:0]    w_wx, w_wy;
  logic [9:0]            w_bin_addr;

  function automatic logic [COUNT_W-1:0] sat_count(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  function automatic logic [STAT_W-1:0] sat_stat(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign w_shot     = iq_valid & bin_en;
  assign w_wx       = {17'b0, x_bin_width};
  assign w_wy       = {17'b0, y_bin_width};
  assign w_bin_addr = {r_idx_y, r_idx_x};

  // Per-axis LOCATE step: an axis that has already resolved stays frozen
  assign w_oor_x = !r_res_x && (r_offx[32] || (x_bin_width == 16'd0) || (r_idx_x == x_bin_num));
  assign w_oor_y = !r_res_y && (r_offy[32] || (y_bin_width == 16'd0) || (r_idx_y == y_bin_num));
  assign w_hit_x = !r_res_x && !w_oor_x && (r_offx < w_wx);
  assign w_hit_y = !r_res_y && !w_oor_y && (r_offy < w_wy);
  assign w_oor   = w_oor_x | w_oor_y;
  assign w_both  = (r_res_x | w_hit_x) & (r_res_y | w_hit_y);

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:  if (r_clr_addr == 10'd1023) w_next = S_IDLE;
      S_IDLE:   if (clear_hist) w_next = S_CLEAR;
                else if (w_shot) w_next = S_LOCATE;
      S_LOCATE: if (w_oor) w_next = S_IDLE;
                else if (w_both) w_next = S_READ;
      S_READ:   w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_CLEAR;
    endcase
  end

  // Shot datapath: offsets are 33-bit so i_val - min never overflows
  always_ff @(posedge clk100) begin
    if (r_state == S_IDLE && !clear_hist && w_shot) begin
      r_offx  <= {i_val[31], i_val} - {{17{x_bin_min[15]}}, x_bin_min};
      r_offy  <= {q_val[31], q_val} - {{17{y_bin_min[15]}}, y_bin_min};
      r_idx_x <= 5'd0;
      r_idx_y <= 5'd0;
      r_res_x <= 1'b0;
      r_res_y <= 1'b0;
    end else if (r_state == S_LOCATE) begin
      if (w_hit_x) r_res_x <= 1'b1;
      else if (!r_res_x && !w_oor_x) begin
        r_offx  <= r_offx - w_wx;
        r_idx_x <= r_idx_x + 5'd1;
      end
      if (w_hit_y) r_res_y <= 1'b1;
      else if (!r_res_y && !w_oor_y) begin
        r_offy  <= r_offy - w_wy;
        r_idx_y <= r_idx_y + 5'd1;
      end
    end
    if (r_state == S_READ) r_cnt <= r_mem[w_bin_addr];
  end

  always_ff @(posedge clk100) begin
    if (r_state == S_CLEAR)      r_mem[r_clr_addr] <= '0;
    else if (r_state == S_WRITE) r_mem[w_bin_addr] <= sat_count(r_cnt);
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_clr_addr   <= 10'd0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_bin_done   <= 1'b0;
      r_bin_oor    <= 1'b0;
      r_bin_x      <= 5'd0;
      r_bin_y      <= 5'd0;
      r_shot_count <= 32'd0;
      r_oor_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_bin_done <= 1'b0;
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= (r_state == S_CLEAR) ? '0 : r_mem[{rd_y, rd_x}];
      r_clr_addr <= (r_state == S_CLEAR) ? r_clr_addr + 10'd1 : 10'd0;
      case (r_state)
        S_IDLE: if (clear_hist) begin
          r_shot_count <= 32'd0;
          r_oor_count  <= '0;
          r_drop_count <= w_shot ? STAT_W'(1) : '0;
        end
        S_LOCATE: if (w_oor) begin
          r_bin_done  <= 1'b1;
          r_bin_oor   <= 1'b1;
          r_bin_x     <= r_idx_x;
          r_bin_y     <= r_idx_y;
          r_oor_count <= sat_stat(r_oor_count);
        end
        S_WRITE: begin
          r_bin_done   <= 1'b1;
          r_bin_oor    <= 1'b0;
          r_bin_x      <= r_idx_x;
          r_bin_y      <= r_idx_y;
          r_shot_count <= r_shot_count + 32'd1;
        end
        default: ;
      endcase
      if (w_shot && r_state != S_IDLE) r_drop_count <= sat_stat(r_drop_count);
    end
  end

  assign ready      = (r_state == S_IDLE);
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign bin_done   = r_bin_done;
  assign bin_oor    = r_bin_oor;
  assign bin_x      = r_bin_x;
  assign bin_y      = r_bin_y;
  assign shot_count = r_shot_count;
  assign oor_count  = r_oor_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_iq_binner.sv
// Scoreboard bench for iq_binner: a division-based reference model predicts each bin_done
// and read response; a separate monitor pops and compares them as the DUT presents them.
module tb_iq_binner;
  localparam int CW = 2;
  localparam int SW = 4;

  logic               clk100 = 1'b0;
  logic               reset  = 1'b0;
  logic               bin_en, iq_valid, clear_hist, rd_en;
  logic signed [31:0] i_val, q_val;
  logic signed [15:0] x_bin_min, y_bin_min;
  logic [15:0]        x_bin_width, y_bin_width;
  logic [4:0]         x_bin_num, y_bin_num, rd_x, rd_y;
  logic [CW-1:0]      rd_data;
  logic               rd_valid, ready, bin_done, bin_oor;
  logic [4:0]         bin_x, bin_y;
  logic [31:0]        shot_count;
  logic [SW-1:0]      oor_count, drop_count;

  iq_binner #(.COUNT_W(CW), .STAT_W(SW)) dut (
    .clk100(clk100), .reset(reset), .bin_en(bin_en), .iq_valid(iq_valid),
    .i_val(i_val), .q_val(q_val), .x_bin_min(x_bin_min), .y_bin_min(y_bin_min),
    .x_bin_width(x_bin_width), .y_bin_width(y_bin_width),
    .x_bin_num(x_bin_num), .y_bin_num(y_bin_num), .clear_hist(clear_hist),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
    .ready(ready), .bin_done(bin_done), .bin_x(bin_x), .bin_y(bin_y), .bin_oor(bin_oor),
    .shot_count(shot_count), .oor_count(oor_count), .drop_count(drop_count)
  );

  always #5 clk100 = ~clk100;

  longint cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  typedef struct { bit oor; longint x; longint y; longint at; } bexp_t;
  typedef struct { longint d; longint at; } rexp_t;
  bexp_t  sbq[$];
  rexp_t  rdq[$];
  longint hist [1024];
  logic [31:0] m_shot;
  longint m_oor, m_drop, busy_until, last_e, last_lat;
  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Reference: index = offset / width; out of range when off<0, width==0 or index>=num
  task automatic axis_model(input longint v, input longint mn, input longint w, input longint n,
                            output bit oor, output longint idx, output longint t);
    longint off, k;
    off = v - mn;
    if (off < 0 || w == 0) begin oor = 1; idx = 0; t = 1; end
    else begin
      k = off / w;
      if (k >= n) begin oor = 1; idx = n; t = n + 1; end
      else        begin oor = 0; idx = k; t = k + 1; end
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 1024; a++) hist[a] = 0;
    m_shot = 32'd0; m_oor = 0; m_drop = 0;
  endtask

  task automatic shot(input longint iv, input longint qv, input bit en);
    bit ox, oy;
    longint ix, iy, tx, ty, lat, e;
    logic [9:0] a;
    bexp_t b;
    i_val = iv[31:0]; q_val = qv[31:0]; bin_en = en; iq_valid = 1'b1;
    e = cyc + 1;
    if (en) begin
      if (e < busy_until) m_drop = sat(m_drop, SW);
      else begin
        axis_model(iv, longint'(x_bin_min), longint'(x_bin_width), longint'(x_bin_num), ox, ix, tx);
        axis_model(qv, longint'(y_bin_min), longint'(y_bin_width), longint'(y_bin_num), oy, iy, ty);
        if (ox || oy) begin
          lat = (ox && oy) ? ((tx < ty) ? tx : ty) : (ox ? tx : ty);
          m_oor = sat(m_oor, SW);
        end else begin
          lat = ((ix > iy) ? ix : iy) + 3;
          a = 10'(iy * 32 + ix);
          hist[a] = sat(hist[a], CW);
          m_shot = m_shot + 32'd1;
        end
        b.oor = ox || oy; b.x = ix; b.y = iy; b.at = e + lat;
        sbq.push_back(b);
        busy_until = e + lat + 1;
        last_e = e; last_lat = lat;
      end
    end
    @(negedge clk100);
    iq_valid = 1'b0; bin_en = 1'b1;
  endtask

  task automatic rd(input int x, input int y, input longint expd);
    rexp_t r;
    rd_en = 1'b1; rd_x = x[4:0]; rd_y = y[4:0];
    r.d = expd; r.at = cyc + 1;
    rdq.push_back(r);
    @(negedge clk100);
    rd_en = 1'b0;
  endtask

  task automatic rdm(input int x, input int y);
    logic [9:0] a;
    a = 10'(y * 32 + x);
    rd(x, y, hist[a]);
  endtask

  task automatic clr(input bit with_shot);
    longint e;
    clear_hist = 1'b1; iq_valid = with_shot; bin_en = 1'b1;
    e = cyc + 1;
    if (e >= busy_until) begin
      model_reset();
      m_drop = with_shot ? 1 : 0;
      busy_until = e + 1025;
    end else if (with_shot) m_drop = sat(m_drop, SW);
    @(negedge clk100);
    clear_hist = 1'b0; iq_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(cyc + 1 >= busy_until && sbq.size() == 0 && rdq.size() == 0) && n < 4000) begin
      @(negedge clk100);
      n++;
    end
    if (n >= 4000) begin
      ntests++; nfail++;
      $display("FAIL wait_idle: timed out, %0d shots and %0d reads outstanding", sbq.size(), rdq.size());
    end else check("ready_idle", ready, 1);
  endtask

  task automatic check_stats();
    check("shot_count", shot_count, longint'(m_shot));
    check("oor_count", oor_count, m_oor);
    check("drop_count", drop_count, m_drop);
  endtask

  task automatic release_reset();
    int n;
    @(negedge clk100);
    reset = 1'b1;
    busy_until = cyc + 1025;
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge clk100);
      n++;
    end
    check("ready_after_reset_cycles", n, 1024);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_bin_done"}, bin_done, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_bin_oor"}, bin_oor, 0);
    check({tag, "_bin_xy"}, {bin_y, bin_x}, 0);
    check({tag, "_shot_count"}, shot_count, 0);
    check({tag, "_oor_count"}, oor_count, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  function automatic longint pick(input longint mn, input longint w, input longint n);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return mn - longint'($urandom_range(1, 300));
    if (r == 1 || w * n == 0) return mn + w * n + longint'($urandom_range(0, 500));
    return mn + longint'($urandom_range(0, 32'(w * n - 1)));
  endfunction

  initial begin : monitor
    bexp_t b;
    rexp_t r;
    forever begin
      @(negedge clk100);
      if (reset) begin
        if (bin_done) begin
          if (sbq.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL unexpected_bin_done: got bin_done=1, expected 0 (cycle %0d)", cyc);
          end else begin
            b = sbq.pop_front();
            check("done_cycle", cyc, b.at);
            check("bin_oor", bin_oor, longint'(b.oor));
            if (!b.oor) begin
              check("bin_x", bin_x, b.x);
              check("bin_y", bin_y, b.y);
            end
          end
        end else if (sbq.size() > 0 && cyc > sbq[0].at) begin
          b = sbq.pop_front();
          ntests++; nfail++;
          $display("FAIL missing_bin_done: got none by cycle %0d, expected at %0d", cyc, b.at);
        end
        if (rd_valid) begin
          if (rdq.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL unexpected_rd_valid: got rd_valid=1, expected 0 (cycle %0d)", cyc);
          end else begin
            r = rdq.pop_front();
            check("rd_cycle", cyc, r.at);
            check("rd_data", rd_data, r.d);
          end
        end else if (rdq.size() > 0 && cyc > rdq[0].at) begin
          r = rdq.pop_front();
          ntests++; nfail++;
          $display("FAIL missing_rd_valid: got none by cycle %0d, expected at %0d", cyc, r.at);
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    longint old;
    int tmp;
    iq_valid = 1'b0; bin_en = 1'b1; clear_hist = 1'b0; rd_en = 1'b0;
    i_val = '0; q_val = '0; rd_x = '0; rd_y = '0;
    x_bin_min = 16'sd0; y_bin_min = 16'sd0;
    x_bin_width = 16'd100; y_bin_width = 16'd100;
    x_bin_num = 5'd10; y_bin_num = 5'd10;
    busy_until = 0; last_e = 0; last_lat = 0;
    model_reset();
    repeat (3) @(negedge clk100);
    check_zero_outputs("reset");
    release_reset();
    rd(3, 4, 0);
    wait_idle();

    shot(250, 730, 1);
    wait_idle();
    rdm(2, 7);
    wait_idle();
    check_stats();

    shot(-5, 50, 1);
    wait_idle();
    shot(1000, 50, 1);
    wait_idle();
    check_stats();
    rdm(2, 7);

    repeat (4) begin shot(30, 40, 1); wait_idle(); end
    rdm(0, 0);
    wait_idle();
    check_stats();

    shot(250, 730, 1);
    @(negedge clk100);
    shot(250, 730, 1);
    wait_idle();
    check_stats();
    shot(450, 450, 0);
    repeat (20) @(negedge clk100);
    check_stats();

    old = hist[10'(7 * 32 + 2)];
    shot(250, 730, 1);
    repeat (int'(last_lat) - 1) @(negedge clk100);
    rd(2, 7, old);
    wait_idle();
    rdm(2, 7);
    wait_idle();

    x_bin_min = -16'sd32768; x_bin_width = 16'd1; x_bin_num = 5'd31;
    shot(64'sd2147483647, 50, 1);
    wait_idle();
    x_bin_min = 16'sd32767;
    shot(-64'sd2147483648, 50, 1);
    wait_idle();
    x_bin_min = 16'sd0; x_bin_width = 16'd0; x_bin_num = 5'd10;
    shot(50, 50, 1);
    wait_idle();
    x_bin_width = 16'd100;
    check_stats();

    clr(1);
    check("ready_in_clear", ready, 0);
    rd(2, 7, 0);
    wait_idle();
    check_stats();
    rdm(2, 7);
    rdm(0, 0);
    wait_idle();

    for (int n = 0; n < 160; n++) begin
      if (n % 20 == 0) begin
        wait_idle();
        check_stats();
        for (int k = 0; k < 4; k++) rdm($urandom_range(0, 31), $urandom_range(0, 31));
        wait_idle();
        tmp = int'($urandom_range(0, 2000)) - 1000; x_bin_min = tmp[15:0];
        tmp = int'($urandom_range(0, 2000)) - 1000; y_bin_min = tmp[15:0];
        x_bin_width = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
        y_bin_width = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
        x_bin_num = 5'($urandom_range(0, 31));
        y_bin_num = 5'($urandom_range(0, 31));
      end
      repeat ($urandom_range(0, 12)) @(negedge clk100);
      shot(pick(longint'(x_bin_min), longint'(x_bin_width), longint'(x_bin_num)),
           pick(longint'(y_bin_min), longint'(y_bin_width), longint'(y_bin_num)),
           $urandom_range(0, 7) != 0);
    end
    wait_idle();
    check_stats();

    x_bin_min = 16'sd0; y_bin_min = 16'sd0;
    x_bin_width = 16'd100; y_bin_width = 16'd100;
    x_bin_num = 5'd10; y_bin_num = 5'd31;
    shot(250, 730, 1);
    wait_idle();
    shot(250, 2500, 1);
    repeat (4) @(negedge clk100);
    #2 reset = 1'b0;
    #1 check_zero_outputs("async_reset");
    sbq.delete();
    rdq.delete();
    model_reset();
    repeat (2) @(negedge clk100);
    release_reset();
    rdm(2, 7);
    wait_idle();
    shot(250, 730, 1);
    wait_idle();
    rdm(2, 7);
    wait_idle();
    check_stats();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
